spi_master: RTL and testbench

Clocked SPI initiator that runs single-byte READ (0x03) and WRITE (0x02) transactions against the lab's 16-bit-address SPI memory slave. It generates csb/sck/si from one system clock and captures so. It sits between a simple start/done command port (CPU, FSM or test sequencer) and the slave's serial pins. Each transaction is 8 instruction bits, then 16 address bits, then 8 data bits, all MSB first, in SPI mode 0.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_tick_gen.sv | 15 +
 rtl/spi_master.sv | 87 ++++++++
 tb/tb_spi_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared command codes, frame geometry and FSM encoding for spi_master
package spi_pkg;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int SPI_FRAME_BITS = 32;
    localparam int SPI_DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, LEAD, HI, LO, TAIL, GAP} spi_state_t;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: CLK_DIV down-counter whose zero marks the last cycle of an FSM phase
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) cnt <= (rst || load) ? TOP : cnt - 1'b1;
    assign tick = cnt == '0;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator running one-byte READ/WRITE frames to a 16-bit-address slave
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        csb,
    output logic        sck,
    output logic        si,
    input  logic        so
);
    localparam int BW = $clog2(SPI_FRAME_BITS);
    spi_state_t state, state_n;
    logic tick, load, accept, hi_entry, lo_entry, fin, active;
    logic [SPI_FRAME_BITS-1:0] frame, frame_ld;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [SPI_DATA_BITS-1:0] rsh;
    logic is_rd;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .load(load), .tick(tick));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LEAD : IDLE;
            LEAD:    state_n = tick ? HI : LEAD;
            HI:      state_n = tick ? (bit_cnt == BW'(SPI_FRAME_BITS - 1) ? TAIL : LO) : HI;
            LO:      state_n = tick ? HI : LO;
            TAIL:    state_n = tick ? GAP : TAIL;
            GAP:     state_n = tick ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    assign accept = state == IDLE && start;
    assign load = state == IDLE || tick;
    assign hi_entry = state_n == HI && state != HI;
    assign lo_entry = state == HI && state_n == LO;
    assign fin = state == GAP && tick;
    assign active = state_n inside {LEAD, HI, LO};
    // bit_cnt is preloaded to all-ones so the first HI entry wraps it to bit 0
    assign bit_nxt = bit_cnt + 1'b1;
    assign frame_ld = {wr ? SPI_CMD_WRITE : SPI_CMD_READ, addr, wr ? wdata : 8'h00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            frame <= '0;
            bit_cnt <= '0;
            rsh <= '0;
            is_rd <= 1'b0;
            rdata <= '0;
            csb <= 1'b1;
            sck <= 1'b0;
            si <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            csb <= !(active || state_n == TAIL);
            sck <= state_n == HI;
            busy <= state_n != IDLE;
            done <= fin;
            si <= accept ? frame_ld[SPI_FRAME_BITS-1] : lo_entry ? frame[SPI_FRAME_BITS-2] : active && si;
            if (accept) begin
                frame <= frame_ld;
                is_rd <= !wr;
                bit_cnt <= '1;
            end
            if (lo_entry) frame <= frame << 1;
            if (hi_entry) bit_cnt <= bit_nxt;
            // so is captured on the edge that raises sck, only for the data byte of a READ
            if (hi_entry && is_rd && bit_nxt >= BW'(SPI_FRAME_BITS - SPI_DATA_BITS))
                rsh <= {rsh[SPI_DATA_BITS-2:0], so};
            if (fin && is_rd) rdata <= rsh;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master at CLK_DIV=2 (index 0) and CLK_DIV=1 (index 1)
module tb_spi_master;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] start = '0, wr = '0, busy, done, csb, sck, si, so;
    logic [1:0][15:0] addr = '0;
    logic [1:0][7:0] wdata = '0, rdata;
    logic [31:0] cap0 = '0, cap1 = '0;
    int rises0 = 0, rises1 = 0;
    logic [7:0] ret0 = '0, ret1 = '0;
    int cyc = 0, checks = 0, errors = 0;

    spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .start(start[0]), .wr(wr[0]), .addr(addr[0]),
        .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .csb(csb[0]), .sck(sck[0]),
        .si(si[0]), .so(so[0]));
    spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .start(start[1]), .wr(wr[1]), .addr(addr[1]),
        .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .csb(csb[1]), .sck(sck[1]),
        .si(si[1]), .so(so[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // slave models: shift si in on sck rise, clear on select, return retN during bits 24..31
    always @(posedge sck[0] or negedge csb[0])
        if (!sck[0]) begin
            cap0 <= '0;
            rises0 <= 0;
        end else begin
            cap0 <= {cap0[30:0], si[0]};
            rises0 <= rises0 + 1;
        end
    always @(posedge sck[1] or negedge csb[1])
        if (!sck[1]) begin
            cap1 <= '0;
            rises1 <= 0;
        end else begin
            cap1 <= {cap1[30:0], si[1]};
            rises1 <= rises1 + 1;
        end
    assign so[0] = (rises0 >= 24 && rises0 < 32) ? ret0[3'(31 - rises0)] : 1'b0;
    assign so[1] = (rises1 >= 24 && rises1 < 32) ? ret1[3'(31 - rises1)] : 1'b0;

    task automatic run(input int s, input logic w, input logic [15:0] a, input logic [7:0] d,
                       output int lat, output int per, output logic [1:0] bc);
        int t0, r0;
        logic ps;
        @(negedge clk);
        start[s] = 1'b1; wr[s] = w; addr[s] = a; wdata[s] = d;
        t0 = cyc + 1;
        @(negedge clk);
        start[s] = 1'b0;
        bc = {busy[s], csb[s]};
        lat = -1; per = -1; r0 = -1; ps = sck[s];
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sck[s] && !ps) begin
                if (r0 < 0) r0 = cyc;
                else if (per < 0) per = cyc - r0;
            end
            ps = sck[s];
            if (done[s]) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 2'b11;
        repeat (3) @(negedge clk);
        checks++; if (csb !== 2'b11) begin errors++; $display("FAIL reset_csb: got %b want 11", csb); end
        checks++; if (sck !== 2'b00) begin errors++; $display("FAIL reset_sck: got %b want 00", sck); end
        checks++; if (si !== 2'b00) begin errors++; $display("FAIL reset_si: got %b want 00", si); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
        checks++; if (rdata[0] !== 8'h00 || rdata[1] !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", rdata[0], rdata[1]);
        end
        start = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        int lat, per;
        logic [1:0] bc;
        ret0 = 8'hFF;
        run(0, 1'b1, 16'h0003, 8'h56, lat, per, bc);
        checks++; if (bc !== 2'b10) begin errors++; $display("FAIL wr_busy_csb: got %b want 10", bc); end
        checks++; if (cap0 !== 32'h0200_0356) begin errors++; $display("FAIL wr_frame: got %h want 02000356", cap0); end
        checks++; if (rises0 !== 32) begin errors++; $display("FAIL wr_rises: got %0d want 32", rises0); end
        checks++; if (lat !== 132) begin errors++; $display("FAIL wr_done_time: got %0d want 132", lat); end
        checks++; if (per !== 4) begin errors++; $display("FAIL wr_sck_period: got %0d want 4", per); end
        checks++; if (rdata[0] !== 8'h00) begin errors++; $display("FAIL wr_rdata: got %h want 00", rdata[0]); end
    endtask

    task automatic test_read();
        int lat, per;
        logic [1:0] bc;
        run(0, 1'b1, 16'h0031, 8'h75, lat, per, bc);
        checks++; if (cap0 !== 32'h0200_3175) begin errors++; $display("FAIL rd_pre_write: got %h want 02003175", cap0); end
        ret0 = 8'h75;
        run(0, 1'b0, 16'h0031, 8'hEE, lat, per, bc);
        checks++; if (cap0 !== 32'h0300_3100) begin errors++; $display("FAIL rd_frame: got %h want 03003100", cap0); end
        checks++; if (rdata[0] !== 8'h75) begin errors++; $display("FAIL rd_rdata: got %h want 75", rdata[0]); end
        checks++; if (lat !== 132) begin errors++; $display("FAIL rd_done_time: got %0d want 132", lat); end
    endtask

    task automatic test_start_ignored();
        int t0, lat, nd;
        @(negedge clk);
        start[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0A0B; wdata[0] = 8'h0C;
        t0 = cyc + 1;
        @(negedge clk);
        start[0] = 1'b0;
        nd = 0; lat = -1;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            start[0] = i < 120 && i % 9 == 4;
            addr[0] = 16'hFFFF; wr[0] = 1'b0;
            if (done[0]) begin
                nd++;
                if (lat < 0) lat = cyc - t0;
            end
        end
        start[0] = 1'b0;
        checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", nd); end
        checks++; if (lat !== 132) begin errors++; $display("FAIL ign_done_time: got %0d want 132", lat); end
        checks++; if (cap0 !== 32'h020A_0B0C) begin errors++; $display("FAIL ign_frame: got %h want 020A0B0C", cap0); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ign_not_queued: got busy %b want 0", busy[0]); end
    endtask

    task automatic test_back_to_back();
        int t0, lat, dn, hi, ng;
        int g [2];
        logic pc;
        @(negedge clk);
        start[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h1234; wdata[0] = 8'h9A;
        t0 = cyc + 1;
        dn = 0; hi = 0; ng = 0; lat = -1; pc = 1'b1; g[0] = -1; g[1] = -1;
        for (int i = 0; i < 600 && dn < 3; i++) begin
            @(negedge clk);
            if (csb[0]) hi++;
            else begin
                if (pc && hi > 0 && ng < 2) begin g[ng] = hi; ng++; end
                hi = 0;
            end
            pc = csb[0];
            if (done[0]) begin dn++; lat = cyc - t0; end
            if (dn == 2 && busy[0]) start[0] = 1'b0;
        end
        start[0] = 1'b0;
        checks++; if (dn !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dn); end
        checks++; if (lat !== 398) begin errors++; $display("FAIL b2b_total_time: got %0d want 398", lat); end
        checks++; if (g[0] !== 3 || g[1] !== 3) begin errors++; $display("FAIL b2b_gap: got %0d/%0d want 3/3", g[0], g[1]); end
        checks++; if (cap0 !== 32'h0212_349A) begin errors++; $display("FAIL b2b_frame: got %h want 0212349A", cap0); end
        repeat (5) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy %b want 0", busy[0]); end
    endtask

    task automatic test_reset_mid();
        int lat, per, nd;
        logic [1:0] bc;
        ret0 = 8'h3C;
        @(negedge clk);
        start[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0031;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 200 && rises0 < 12; i++) @(negedge clk);
        checks++; if (rises0 !== 12) begin errors++; $display("FAIL mid_reach_bit12: got %0d want 12", rises0); end
        rst = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        checks++; if ({csb[0], sck[0], si[0], busy[0], done[0]} !== 5'b10000) begin
            errors++; $display("FAIL mid_reset_pins: got csb%b sck%b si%b busy%b done%b want 1 0 0 0 0",
                                csb[0], sck[0], si[0], busy[0], done[0]);
        end
        checks++; if (rdata[0] !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %h want 00", rdata[0]); end
        start[0] = 1'b0;
        rst = 1'b0;
        nd = 0;
        repeat (150) begin
            @(negedge clk);
            if (done[0] || busy[0]) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mid_no_done: got %0d active cycles want 0", nd); end
        run(0, 1'b1, 16'hBEEF, 8'hA5, lat, per, bc);
        checks++; if (cap0 !== 32'h02BE_EFA5) begin errors++; $display("FAIL mid_next_frame: got %h want 02BEEFA5", cap0); end
        checks++; if (lat !== 132) begin errors++; $display("FAIL mid_next_time: got %0d want 132", lat); end
    endtask

    task automatic test_clkdiv1();
        int lat, per;
        logic [1:0] bc;
        ret1 = 8'h56;
        run(1, 1'b0, 16'h0003, 8'h00, lat, per, bc);
        checks++; if (bc !== 2'b10) begin errors++; $display("FAIL d1_busy_csb: got %b want 10", bc); end
        checks++; if (rdata[1] !== 8'h56) begin errors++; $display("FAIL d1_rdata: got %h want 56", rdata[1]); end
        checks++; if (lat !== 66) begin errors++; $display("FAIL d1_done_time: got %0d want 66", lat); end
        checks++; if (per !== 2) begin errors++; $display("FAIL d1_sck_period: got %0d want 2", per); end
        checks++; if (cap1 !== 32'h0300_0300) begin errors++; $display("FAIL d1_frame: got %h want 03000300", cap1); end
        checks++; if (rises1 !== 32) begin errors++; $display("FAIL d1_rises: got %0d want 32", rises1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
